// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one partial-product step per clock, WIDTH steps per product.
// Signed mode multiplies operand magnitudes and negates the result when the signs differ.
module seq_multiplier #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 is_signed,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   z
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   // Handshake: start is accepted on an edge where busy=0 (IDLE or DONE); a, b and
   // is_signed are captured on that edge only. done is a one-cycle pulse with z valid.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state;
   logic [WIDTH-1:0]     mcand;
   logic [2*WIDTH-1:0]   acc;
   logic                 neg;
   logic [CW-1:0]        cnt;

   logic [WIDTH-1:0]     a_mag;
   logic [WIDTH-1:0]     b_mag;
   logic [WIDTH:0]       sum;
   logic [2*WIDTH-1:0]   acc_nxt;

   // The magnitude of -2^(W-1) is 2^(W-1), which still fits in WIDTH unsigned bits.
   always_comb begin
      a_mag   = (is_signed && a[WIDTH-1]) ? -a : a;
      b_mag   = (is_signed && b[WIDTH-1]) ? -b : b;
      sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
      acc_nxt = {sum, acc[WIDTH-1:1]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         z     <= '0;
         mcand <= '0;
         acc   <= '0;
         neg   <= 1'b0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  mcand <= a_mag;
                  acc   <= {{WIDTH{1'b0}}, b_mag};
                  neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            RUN: begin
               acc <= acc_nxt;
               cnt <= cnt + CW'(1);
               if (cnt == CW'(WIDTH - 1)) begin
                  z     <= neg ? -acc_nxt : acc_nxt;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
